// File: rtl/grf_multiport.sv
// Multi-read-port general register file with optional write-to-read forwarding,
// register 0 hardwired to zero, and a valid/ready commit-log FIFO of every write.
module grf_multiport #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int LOG_DEPTH = 8,
  parameter int PC_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PC_W-1:0]            pc,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [PC_W-1:0]            log_pc,
  output logic [ADDR_W-1:0]          log_addr,
  output logic [DATA_W-1:0]          log_data,
  output logic [$clog2(LOG_DEPTH):0] log_count,
  output logic [15:0]                log_drop
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int PTR_W    = $clog2(LOG_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } log_entry_t;

  // ---------------------------------------------------------------------------
  // Architectural registers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: the register array is reset element by element because its contents
  // are architecturally visible after reset; the log storage below is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Zero-latency reads; index 0 wins over forwarding so r0 can never be non-zero.
  always_comb begin
    // NOTE: a full default before the loop keeps every bit assigned on every
    // path, so no latch is inferred.
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (raddr[k*ADDR_W +: ADDR_W] == '0) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && we && (waddr == raddr[k*ADDR_W +: ADDR_W])) begin
        rdata[k*DATA_W +: DATA_W] = wdata;
      end else begin
        rdata[k*DATA_W +: DATA_W] = regs[raddr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit-log FIFO
  // ---------------------------------------------------------------------------
  log_entry_t       log_mem [LOG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  log_entry_t       head;

  assign log_valid = (log_count != '0);
  assign full      = (log_count == CNT_W'(LOG_DEPTH));
  assign pop       = log_valid && log_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok   = we && (!full || pop);
  assign drop      = we && full && !pop;

  // Entry storage only; occupancy tracking decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      log_mem[wr_ptr] <= '{pc: pc, addr: waddr, data: wdata};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_count <= '0;
      log_drop  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   log_count <= log_count + CNT_W'(1);
        2'b01:   log_count <= log_count - CNT_W'(1);
        default: log_count <= log_count;
      endcase
      if (drop && (log_drop != 16'hFFFF)) begin
        log_drop <= log_drop + 16'd1;
      end
    end
  end

  // Head is a pure function of rd_ptr, so it holds steady while stalled.
  assign head     = log_mem[rd_ptr];
  assign log_pc   = head.pc;
  assign log_addr = head.addr;
  assign log_data = head.data;

endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport: a driver pushes expected log records into a
// scoreboard queue and a negedge monitor compares every popped log entry.
`timescale 1ns/1ps
module tb_grf_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [63:0] nb_rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        log_valid, log_ready;
  logic [31:0] log_pc, log_data;
  logic [4:0]  log_addr;
  logic [3:0]  log_count;
  logic [15:0] log_drop;
  logic        nb_log_valid;
  logic [31:0] nb_log_pc, nb_log_data;
  logic [4:0]  nb_log_addr;
  logic [3:0]  nb_log_count;
  logic [15:0] nb_log_drop;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_drop = 0;

  always #10 clk = ~clk;

  grf_multiport #(.BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .pc(pc), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .log_valid(log_valid), .log_ready(log_ready), .log_pc(log_pc),
    .log_addr(log_addr), .log_data(log_data), .log_count(log_count),
    .log_drop(log_drop)
  );

  grf_multiport #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .pc(pc), .raddr(raddr), .rdata(nb_rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .log_valid(nb_log_valid), .log_ready(log_ready), .log_pc(nb_log_pc),
    .log_addr(nb_log_addr), .log_data(nb_log_data), .log_count(nb_log_count),
    .log_drop(nb_log_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the expected log record is queued unless the model
  // FIFO is full with no pop this edge, in which case a drop is expected.
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic rdy);
    rec_t r;
    @(posedge clk);
    #1;
    we = w; waddr = a; wdata = d; pc = p; log_ready = rdy;
    if (w) begin
      if (exp_q.size() < 8 || (exp_q.size() != 0 && rdy)) begin
        r.pc = p; r.addr = a; r.data = d;
        exp_q.push_back(r);
      end else begin
        model_drop++;
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(log_valid), 64'd0);
  endtask

  // Monitor: each accepted handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (reset && log_valid && log_ready) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_pop", 64'd1, 64'd0);
      end else begin
        check("mon_pc",   64'(log_pc),   64'(exp_q[0].pc));
        check("mon_addr", 64'(log_addr), 64'(exp_q[0].addr));
        check("mon_data", 64'(log_data), 64'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; pc = '0; log_ready = 1'b0;
    raddr = {5'd31, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd0",   rdata[31:0],  64'd0);
    check("rst_rd1",   rdata[63:32], 64'd0);
    check("rst_valid", 64'(log_valid), 64'd0);
    check("rst_count", 64'(log_count), 64'd0);
    check("rst_drop",  64'(log_drop),  64'd0);
    reset = 1'b1;

    // Write/read with and without forwarding
    raddr = {5'd0, 5'd3};
    drive(1'b1, 5'd3, 32'hDEADBEEF, 32'h1000, 1'b0);
    check("byp_rd0",    rdata[31:0],    64'hDEADBEEF);
    check("nobyp_rd0",  nb_rdata[31:0], 64'd0);
    check("byp_rd1_r0", rdata[63:32],   64'd0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("stored_rd0",    rdata[31:0],    64'hDEADBEEF);
    check("nb_stored_rd0", nb_rdata[31:0], 64'hDEADBEEF);
    check("wr_count",      64'(log_count), 64'd1);
    drain();

    // Zero register
    raddr = {5'd0, 5'd0};
    drive(1'b1, 5'd0, 32'h1234, 32'h2000, 1'b0);
    check("r0_byp_rd0", rdata[31:0],    64'd0);
    check("r0_byp_rd1", rdata[63:32],   64'd0);
    check("r0_nb_rd0",  nb_rdata[31:0], 64'd0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("r0_rd0",   rdata[31:0],    64'd0);
    check("r0_laddr", 64'(log_addr),  64'd0);
    check("r0_ldata", 64'(log_data),  64'h1234);
    check("r0_lpc",   64'(log_pc),    64'h2000);
    check("r0_count", 64'(log_count), 64'd1);
    drain();

    // Ordering and drain
    drive(1'b1, 5'd1, 32'hAAAA0001, 32'h3000, 1'b0);
    drive(1'b1, 5'd2, 32'hBBBB0002, 32'h3004, 1'b0);
    drive(1'b1, 5'd4, 32'hCCCC0004, 32'h3008, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("ord_count", 64'(log_count), 64'd3);
    check("ord_head",  64'(log_pc),    64'h3000);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("ord_hold",  64'(log_pc),    64'h3000);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("ord_pop1_head", 64'(log_pc), 64'h3000);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("ord_pop2_head", 64'(log_pc),    64'h3004);
    check("ord_pop2_cnt",  64'(log_count), 64'd2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("ord_pop3_head", 64'(log_pc),    64'h3008);
    check("ord_pop3_cnt",  64'(log_count), 64'd1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("ord_empty_valid", 64'(log_valid), 64'd0);
    check("ord_empty_left",  64'(exp_q.size()), 64'd0);
    raddr = {5'd2, 5'd4};
    #1;
    check("ord_rd0", rdata[31:0],  64'hCCCC0004);
    check("ord_rd1", rdata[63:32], 64'hBBBB0002);

    // Overflow
    for (int i = 0; i < 10; i++)
      drive(1'b1, 5'(8 + i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("ovf_count",   64'(log_count), 64'd8);
    check("ovf_drop",    64'(log_drop),  64'd2);
    check("ovf_drop_m",  64'(log_drop),  64'(model_drop));
    check("ovf_head_pc", 64'(log_pc),    64'h4000);
    check("ovf_head_a",  64'(log_addr),  64'd8);
    check("ovf_rd_r17",  64'(rdata[31:0]), 64'hCCCC0004);
    check("nb_ovf_valid", 64'(nb_log_valid), 64'd1);
    check("nb_ovf_count", 64'(nb_log_count), 64'd8);
    check("nb_ovf_drop",  64'(nb_log_drop),  64'd2);
    check("nb_ovf_pc",    64'(nb_log_pc),    64'h4000);
    check("nb_ovf_addr",  64'(nb_log_addr),  64'd8);
    check("nb_ovf_data",  64'(nb_log_data),  64'h100);
    drive(1'b1, 5'd20, 32'h200, 32'h4028, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("full_pp_count", 64'(log_count), 64'd8);
    check("full_pp_drop",  64'(log_drop),  64'd2);
    check("full_pp_head",  64'(log_pc),    64'h4004);

    // Async reset with entries pending
    repeat (3) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("pre_rst_count", 64'(log_count), 64'd5);
    raddr = {5'd4, 5'd3};
    #1;
    check("pre_rst_rd0", rdata[31:0], 64'hDEADBEEF);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_drop = 0;
    #1;
    check("arst_valid", 64'(log_valid),   64'd0);
    check("arst_count", 64'(log_count),   64'd0);
    check("arst_drop",  64'(log_drop),    64'd0);
    check("arst_rd0",   rdata[31:0],      64'd0);
    check("arst_rd1",   rdata[63:32],     64'd0);
    check("arst_nb_rd0", nb_rdata[31:0],  64'd0);
    #2;
    reset = 1'b1;
    drive(1'b1, 5'd7, 32'h77, 32'h5000, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("post_count", 64'(log_count), 64'd1);
    check("post_addr",  64'(log_addr),  64'd7);
    check("post_data",  64'(log_data),  64'h77);
    check("post_pc",    64'(log_pc),    64'h5000);
    raddr = {5'd0, 5'd7};
    #1;
    check("post_rd0", rdata[31:0], 64'h77);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
